// File: rtl/hdp_spi_pkg.sv
// Shared definitions for the HDP-1280-2 SPI link: responder states, frame
// geometry and the RW flag encoding that the initiator side uses as well.
package hdp_spi_pkg;

  localparam int HDP_WORD_WIDTH = 8;
  localparam int FRAME_BITS     = 2 * HDP_WORD_WIDTH;
  localparam int RW_BIT         = HDP_WORD_WIDTH - 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_OVERRUN,
    ST_WAIT_CS
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by an edge
// register that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Deliberately not reset: the chain keeps tracking the pin during reset so
  // that releasing reset never manufactures a false edge.
  always_ff @(posedge clk) begin
    sync_q[0] <= din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/hdp_spi_responder.sv
// Mode-0 SPI responder for 16-bit HDP register frames: oversamples the pins,
// decodes the RW/address byte and drives a read/write strobe register port.
module hdp_spi_responder
  import hdp_spi_pkg::*;
#(
  parameter int WORD_WIDTH  = HDP_WORD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [WORD_WIDTH-1:0] status_byte,
  output logic [WORD_WIDTH-2:0] reg_addr,
  output logic                  reg_rd_en,
  input  logic [WORD_WIDTH-1:0] reg_rd_data,
  output logic                  reg_wr_en,
  output logic [WORD_WIDTH-1:0] reg_wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error,
  output state_t                state
);

  localparam logic [4:0] BYTE_CNT  = 5'(WORD_WIDTH);
  localparam logic [4:0] FRAME_CNT = 5'(2 * WORD_WIDTH);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  logic [4:0]            bit_cnt;
  logic [WORD_WIDTH-1:0] rx_sr, tx_sr, rx_next;
  logic                  rw_flag, rd_load;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(sys_clk), .din(SCLK), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(sys_clk), .din(CS), .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI gets the same depth as SCLK so a detected rise lines up with its bit.
  always_ff @(posedge sys_clk) begin
    mosi_q[0] <= MOSI;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_q[i] <= mosi_q[i-1];
    end
  end

  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rx_next = {rx_sr[WORD_WIDTH-2:0], mosi_s};
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rw_flag     <= RW_WRITE;
      rd_load     <= 1'b0;
      MISO        <= 1'b0;
      MISO_OE     <= 1'b0;
      reg_addr    <= '0;
      reg_rd_en   <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      reg_rd_en   <= 1'b0;
      reg_wr_en   <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      // The bank answers one cycle after the strobe; capture it then.
      rd_load     <= reg_rd_en;
      if (rd_load) tx_sr <= reg_rd_data;

      case (state)
        ST_IDLE: begin
          if (cs_fall && enable) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= {status_byte[WORD_WIDTH-2:0], 1'b0};
            MISO    <= status_byte[WORD_WIDTH-1];
            MISO_OE <= 1'b1;
          end else if (!cs_s) begin
            // Covers CS fall with enable low and CS already low out of reset.
            state <= ST_WAIT_CS;
          end
        end

        ST_ADDR, ST_DATA: begin
          if (cs_rise) begin
            state       <= ST_IDLE;
            frame_error <= 1'b1;
            MISO        <= 1'b0;
            MISO_OE     <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (state == ST_ADDR && (bit_cnt + 5'd1) == BYTE_CNT) begin
              state    <= ST_DATA;
              reg_addr <= rx_next[WORD_WIDTH-2:0];
              rw_flag  <= rx_next[WORD_WIDTH-1];
              if (rx_next[WORD_WIDTH-1] == RW_READ) reg_rd_en <= 1'b1;
              else                                  tx_sr     <= '0;
            end else if ((bit_cnt + 5'd1) == FRAME_CNT) begin
              state <= ST_OVERRUN;
              MISO  <= 1'b0;
            end
          end else if (sclk_fall) begin
            MISO  <= tx_sr[WORD_WIDTH-1];
            tx_sr <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
          end
        end

        ST_OVERRUN: begin
          if (cs_rise) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            MISO       <= 1'b0;
            MISO_OE    <= 1'b0;
            if (bit_cnt == FRAME_CNT && rw_flag == RW_WRITE) begin
              reg_wr_en   <= 1'b1;
              reg_wr_data <= rx_sr;
            end
          end
        end

        ST_WAIT_CS: begin
          if (cs_rise) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdp_spi_responder.sv
// Bench for hdp_spi_responder: table of full frames plus hand-written corner
// sequences, with a strobe scoreboard fed from expected-value queues.
module tb_hdp_spi_responder;
  import hdp_spi_pkg::*;

  localparam int W = HDP_WORD_WIDTH;

  logic         sys_clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         SCLK = 1'b0;
  logic         CS = 1'b1;
  logic         MOSI = 1'b0;
  logic         MISO, MISO_OE;
  logic [W-1:0] status_byte = '0;
  logic [W-2:0] reg_addr;
  logic         reg_rd_en;
  logic [W-1:0] reg_rd_data = '0;
  logic         reg_wr_en;
  logic [W-1:0] reg_wr_data;
  logic         busy, frame_done, frame_error;
  state_t       state;

  hdp_spi_responder #(.WORD_WIDTH(W), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .SCLK(SCLK), .CS(CS),
    .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE), .status_byte(status_byte),
    .reg_addr(reg_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error), .state(state)
  );

  // clock / reset
  always #10 sys_clk = ~sys_clk;

  // register bank model: zero-wait read, one-cycle latency
  logic [W-1:0] bank [128];
  always @(posedge sys_clk) if (reg_rd_en) reg_rd_data <= bank[reg_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [2*W-2:0] exp_wr_q[$];
  logic [W-2:0]   exp_rd_q[$];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic oe_seen = 1'b0;

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (reg_wr_en) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(reg_wr_en), 32'd0);
        else check("wr_addr_data", 32'({reg_addr, reg_wr_data}), 32'(exp_wr_q.pop_front()));
      end
      if (reg_rd_en) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(reg_rd_en), 32'd0);
        else check("rd_addr", 32'(reg_addr), 32'(exp_rd_q.pop_front()));
      end
      if (frame_done)  done_cnt++;
      if (frame_error) err_cnt++;
      if (MISO_OE)     oe_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    wait_clk(10);
    status_byte = ~status_byte;  // must not disturb the byte latched at CS fall
  endtask

  task automatic spi_bit(input logic b, output logic m);
    MOSI = b;
    wait_clk(25);
    m = MISO;
    SCLK = 1'b1;
    wait_clk(25);
    SCLK = 1'b0;
  endtask

  task automatic cs_high();
    wait_clk(10);
    CS = 1'b1;
    wait_clk(12);
  endtask

  task automatic run_frame(input logic [FRAME_BITS-1:0] f, input int nbits, output logic [31:0] mv);
    logic m;
    mv = '0;
    cs_low();
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < FRAME_BITS) ? f[FRAME_BITS-1-i] : 1'b1, m);
      mv = {mv[30:0], m};
    end
    cs_high();
  endtask

  // queue the strobe a full frame is expected to produce
  task automatic expect_frame(input logic [FRAME_BITS-1:0] f);
    if (f[FRAME_BITS-1] == RW_READ) exp_rd_q.push_back(f[FRAME_BITS-2:W]);
    else                            exp_wr_q.push_back(f[FRAME_BITS-2:0]);
  endtask

  typedef struct {
    logic [FRAME_BITS-1:0] frame;
    logic [W-1:0]          status;
    logic [W-1:0]          exp_hi;
    logic [W-1:0]          exp_lo;
    int                    exp_wr;
    int                    exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] mv;
    logic m;
    int wr0, rd0, done0, err0;

    for (int i = 0; i < 128; i++) bank[i] = 8'(i * 37 + 11);
    bank[5] = 8'h5E;

    vecs[0].frame = 16'h05A7; vecs[0].status = 8'h3C;
    vecs[1].frame = 16'h8500; vecs[1].status = 8'hC3;
    vecs[2].frame = 16'h7F00; vecs[2].status = 8'h00;
    vecs[3].frame = 16'h00FF; vecs[3].status = 8'hFF;
    vecs[4].frame = 16'hFF12; vecs[4].status = 8'h81;
    vecs[5].frame = 16'h8055; vecs[5].status = 8'h5A;
    vecs[6].frame = {1'b0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
    vecs[6].status = 8'($urandom_range(0, 255));
    vecs[7].frame = {1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
    vecs[7].status = 8'($urandom_range(0, 255));
    foreach (vecs[i]) begin
      vecs[i].exp_hi = vecs[i].status;
      vecs[i].exp_lo = (vecs[i].frame[FRAME_BITS-1] == RW_READ) ? bank[vecs[i].frame[FRAME_BITS-2:W]] : 8'h00;
      vecs[i].exp_wr = (vecs[i].frame[FRAME_BITS-1] == RW_WRITE) ? 1 : 0;
      vecs[i].exp_rd = 1 - vecs[i].exp_wr;
    end

    // reset values
    wait_clk(6);
    reset = 1'b0;
    wait_clk(2);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_miso_oe", 32'(MISO_OE), 32'd0);
    check("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);

    // table of full frames
    foreach (vecs[i]) begin
      wr0 = wr_cnt; rd0 = rd_cnt; done0 = done_cnt; err0 = err_cnt;
      status_byte = vecs[i].status;
      expect_frame(vecs[i].frame);
      run_frame(vecs[i].frame, FRAME_BITS, mv);
      check($sformatf("v%0d_miso_hi", i), 32'(mv[15:8]), 32'(vecs[i].exp_hi));
      check($sformatf("v%0d_miso_lo", i), 32'(mv[7:0]), 32'(vecs[i].exp_lo));
      check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_done", i), 32'(done_cnt - done0), 32'd1);
      check($sformatf("v%0d_error", i), 32'(err_cnt - err0), 32'd0);
    end

    // short frame: CS rises after 11 bits, then a full frame decodes
    wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt;
    run_frame(16'h0AC3, 11, mv);
    check("short_error", 32'(err_cnt - err0), 32'd1);
    check("short_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("short_no_done", 32'(done_cnt - done0), 32'd0);
    check("short_state", 32'(state), 32'(ST_IDLE));
    expect_frame(16'h0AC3);
    run_frame(16'h0AC3, FRAME_BITS, mv);
    check("after_short_wr", 32'(wr_cnt - wr0), 32'd1);
    check("after_short_done", 32'(done_cnt - done0), 32'd1);

    // 18 SCLK pulses: extra bits ignored, MISO low during them
    wr0 = wr_cnt; done0 = done_cnt;
    status_byte = 8'hA5;
    expect_frame(16'h1234);
    run_frame(16'h1234, 18, mv);
    check("ovr_miso_hi", 32'(mv[17:10]), 32'hA5);
    check("ovr_miso_extra", 32'(mv[1:0]), 32'd0);
    check("ovr_wr", 32'(wr_cnt - wr0), 32'd1);
    check("ovr_done", 32'(done_cnt - done0), 32'd1);

    // reset mid-frame at bit 6, released with CS still low
    wr0 = wr_cnt; rd0 = rd_cnt; done0 = done_cnt; err0 = err_cnt;
    cs_low();
    for (int i = 0; i < 6; i++) spi_bit(1'b1, m);
    reset = 1'b1;
    wait_clk(4);
    check("mid_rst_miso", 32'(MISO), 32'd0);
    check("mid_rst_oe", 32'(MISO_OE), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    wait_clk(3);
    check("mid_rst_wait_cs", 32'(state), 32'(ST_WAIT_CS));
    check("mid_rst_oe_after", 32'(MISO_OE), 32'd0);
    for (int i = 6; i < FRAME_BITS; i++) spi_bit(1'b0, m);
    cs_high();
    check("mid_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("mid_rst_no_rd", 32'(rd_cnt - rd0), 32'd0);
    check("mid_rst_no_done", 32'(done_cnt - done0), 32'd0);
    check("mid_rst_no_err", 32'(err_cnt - err0), 32'd0);
    expect_frame(16'h8500);
    run_frame(16'h8500, FRAME_BITS, mv);
    check("mid_rst_next_lo", 32'(mv[7:0]), 32'h5E);
    check("mid_rst_next_done", 32'(done_cnt - done0), 32'd1);

    // enable low at CS fall: frame is ignored until CS rises
    wr0 = wr_cnt; rd0 = rd_cnt; done0 = done_cnt; err0 = err_cnt;
    enable = 1'b0;
    oe_seen = 1'b0;
    cs_low();
    enable = 1'b1;
    check("dis_busy", 32'(busy), 32'd1);
    check("dis_state", 32'(state), 32'(ST_WAIT_CS));
    for (int i = 0; i < FRAME_BITS; i++) spi_bit(i[0], m);
    check("dis_busy_late", 32'(busy), 32'd1);
    cs_high();
    check("dis_oe", 32'(oe_seen), 32'd0);
    check("dis_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("dis_no_rd", 32'(rd_cnt - rd0), 32'd0);
    check("dis_no_done", 32'(done_cnt - done0), 32'd0);
    check("dis_busy_end", 32'(busy), 32'd0);

    // final report
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
